// File: rtl/stack_unit_pkg.sv
// Shared sizing constants for the return-address stack.
// The count is one bit wider than the address so that a full stack can be told apart from an empty one.
package stack_unit_pkg;
    localparam int STACK_DEPTH = 16;
    localparam int STACK_WIDTH = 8;
    localparam int STACK_CNT_W = $clog2(STACK_DEPTH) + 1;
endpackage

// File: rtl/stack_unit_if.sv
// Control and status bundle between the program counter (master) and stack_unit (slave).
interface stack_unit_if
    import stack_unit_pkg::*;
#(
    parameter int DEPTH = STACK_DEPTH,
    parameter int WIDTH = STACK_WIDTH
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic             push_stack;
    logic [WIDTH-1:0] stack_in;
    logic             pop_1_stack;
    logic             pop_2_stack;
    logic             err_clear;
    logic [WIDTH-1:0] stack_out;
    logic             empty;
    logic             full;
    logic [CW-1:0]    count;
    logic             overflow;
    logic             underflow;
    logic             proto_err;

    modport master (
        output push_stack, stack_in, pop_1_stack, pop_2_stack, err_clear,
        input  stack_out, empty, full, count, overflow, underflow, proto_err
    );

    modport slave (
        input  push_stack, stack_in, pop_1_stack, pop_2_stack, err_clear,
        output stack_out, empty, full, count, overflow, underflow, proto_err
    );
endinterface

// File: rtl/stack_ram.sv
// Stack storage: one synchronous write port, one asynchronous read port, contents not reset.
// Latency: write visible on the read port the cycle after the edge; read is combinational.
// Backpressure: none, every write request is accepted.
module stack_ram #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                     clock,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/stack_unit.sv
// Return-address stack with push/pop, saturating count and sticky error flags.
// Latency: stack_out is combinational from storage; a push or pop is reflected after the next edge.
// Backpressure: none; a push when full or a pop when empty is dropped and flagged.
module stack_unit
    import stack_unit_pkg::*;
#(
    parameter int DEPTH = STACK_DEPTH,
    parameter int WIDTH = STACK_WIDTH
) (
    input  logic         clock,
    input  logic         reset,
    stack_unit_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_nxt;
    logic             overflow_q;
    logic             underflow_q;
    logic             proto_err_q;
    logic             pop;
    logic             is_empty;
    logic             is_full;
    logic             we;
    logic [AW-1:0]    waddr;
    logic [AW-1:0]    raddr;
    logic [WIDTH-1:0] rdata;
    logic             overflow_ev;
    logic             underflow_ev;
    logic             proto_err_ev;

    always_comb begin
        pop          = bus.pop_1_stack | bus.pop_2_stack;
        is_empty     = (count_q == '0);
        is_full      = (count_q == CW'(DEPTH));
        raddr        = AW'(count_q - CW'(1));
        waddr        = count_q[AW-1:0];
        we           = 1'b0;
        count_nxt    = count_q;
        overflow_ev  = 1'b0;
        underflow_ev = 1'b0;
        proto_err_ev = bus.pop_1_stack & bus.pop_2_stack;

        // Push together with a pop replaces the top entry in place.
        if (bus.push_stack && pop && !is_empty) begin
            we    = 1'b1;
            waddr = raddr;
        end else if (bus.push_stack) begin
            if (is_full) begin
                overflow_ev = 1'b1;
            end else begin
                we        = 1'b1;
                count_nxt = count_q + CW'(1);
            end
        end else if (pop) begin
            if (is_empty) begin
                underflow_ev = 1'b1;
            end else begin
                count_nxt = count_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            count_q     <= count_nxt;
            // A new error event in the clearing cycle keeps its flag set.
            overflow_q  <= overflow_ev  | (overflow_q  & ~bus.err_clear);
            underflow_q <= underflow_ev | (underflow_q & ~bus.err_clear);
            proto_err_q <= proto_err_ev | (proto_err_q & ~bus.err_clear);
        end
    end

    stack_ram #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_ram (
        .clock (clock),
        .we    (we),
        .waddr (waddr),
        .wdata (bus.stack_in),
        .raddr (raddr),
        .rdata (rdata)
    );

    assign bus.stack_out = is_empty ? '0 : rdata;
    assign bus.empty     = is_empty;
    assign bus.full      = is_full;
    assign bus.count     = count_q;
    assign bus.overflow  = overflow_q;
    assign bus.underflow = underflow_q;
    assign bus.proto_err = proto_err_q;
endmodule
